// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - serializer types and constants; ST_CSUM and the checksum helper exist only with MIPS_SER_CHECKSUM_EN
package mips_pkg;

    localparam int NUM_REGS     = 6;
    localparam int SEQ_W        = 12;
    localparam int DATA_W       = 16;

    // Header beat layout: fail flag on top, reserved zeros, sequence number below
    localparam int HDR_FAIL_BIT = 15;
    localparam int HDR_RSVD_MSB = 14;
    localparam int HDR_RSVD_LSB = 12;
    localparam int HDR_SEQ_MSB  = 11;
    localparam int HDR_SEQ_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
`ifdef MIPS_SER_CHECKSUM_EN
        ,
        ST_CSUM = 2'd3
`endif
    } ser_state_e;

    typedef struct packed {
        logic                             fail;
        logic [SEQ_W-1:0]                 seq;
        logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
    } snapshot_t;

    function automatic logic [DATA_W-1:0] make_header(input snapshot_t s);
        logic [DATA_W-1:0] h;
        h = '0;
        h[HDR_FAIL_BIT]                = s.fail;
        h[HDR_RSVD_MSB:HDR_RSVD_LSB]   = 3'b000;
        h[HDR_SEQ_MSB:HDR_SEQ_LSB]     = s.seq;
        return h;
    endfunction

`ifdef MIPS_SER_CHECKSUM_EN
    function automatic logic [DATA_W-1:0] snap_checksum(input snapshot_t s);
        logic [DATA_W-1:0] c;
        c = make_header(s);
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c ^ s.regs[i];
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/mips_snapshot_fifo.sv
// rtl/mips_snapshot_fifo.sv - snapshot FIFO with head and head+1 read ports for gapless serialization
module mips_snapshot_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  snapshot_t                    push_data,
    input  logic                         pop,
    output snapshot_t                    head_data,
    output snapshot_t                    next_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    snapshot_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   rd_next;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    // A push into a full FIFO only lands when the head leaves in the same cycle
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign rd_next   = rd_ptr_q + PTR_W'(1);
    assign head_data = mem_q[rd_ptr_q];
    assign next_data = mem_q[rd_next];
    assign count     = count_q;

    // Next-state pointer and occupancy arithmetic
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_next;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Snapshot storage, deliberately left uninitialised by reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mips_result_serializer.sv
// rtl/mips_result_serializer.sv - ALU result snapshot serializer; MIPS_SER_CHECKSUM_EN appends an XOR checksum beat
module mips_result_serializer
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_fail,
    input  logic [15:0]                  in_r0,
    input  logic [15:0]                  in_r1,
    input  logic [15:0]                  in_r2,
    input  logic [15:0]                  in_r3,
    input  logic [15:0]                  in_r4,
    input  logic [15:0]                  in_r5,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_data,
    output logic                         out_last,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int         CNT_W    = $clog2(DEPTH+1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    ser_state_e         state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         idx_nxt;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               overflow_q, overflow_d;

    snapshot_t          in_snap;
    snapshot_t          head_snap;
    snapshot_t          next_snap;
    snapshot_t          follow_snap;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop;
    logic               handshake;
    logic               drop;
    logic               follow_avail;

    assign in_snap   = {in_fail, seq_q, in_r5, in_r4, in_r3, in_r2, in_r1, in_r0};
    assign handshake = out_valid_q && out_ready;
    assign idx_nxt   = idx_q + 3'd1;
    assign drop      = in_valid && fifo_full && !pop;

    // The snapshot after the current one is either already queued, or is the
    // one arriving right now into an otherwise drained FIFO (bypass keeps the
    // stream gapless without waiting for the write to land)
    assign follow_avail = (fifo_count > CNT_W'(1)) || (in_valid && (fifo_count == CNT_W'(1)));
    assign follow_snap  = (fifo_count > CNT_W'(1)) ? next_snap : in_snap;

    mips_snapshot_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (in_valid),
        .push_data  (in_snap),
        .pop        (pop),
        .head_data  (head_snap),
        .next_data  (next_snap),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Serializer next-state and next-beat selection; outputs hold unless a beat is accepted
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d     = ST_HDR;
                    idx_d       = 3'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = make_header(head_snap);
                    out_last_d  = 1'b0;
                end
            end
            ST_HDR: begin
                if (handshake) begin
                    state_d    = ST_DATA;
                    idx_d      = 3'd0;
                    out_data_d = head_snap.regs[0];
                    out_last_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (handshake) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d      = idx_nxt;
                        out_data_d = head_snap.regs[idx_nxt];
`ifdef MIPS_SER_CHECKSUM_EN
                        out_last_d = 1'b0;
`else
                        out_last_d = (idx_nxt == LAST_IDX);
`endif
                    end else begin
`ifdef MIPS_SER_CHECKSUM_EN
                        state_d    = ST_CSUM;
                        out_data_d = snap_checksum(head_snap);
                        out_last_d = 1'b1;
`else
                        pop        = 1'b1;
`endif
                    end
                end
            end
`ifdef MIPS_SER_CHECKSUM_EN
            ST_CSUM: begin
                if (handshake) begin
                    pop = 1'b1;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Final beat accepted: chain straight into the next header or go idle
        if (pop) begin
            idx_d = 3'd0;
            if (follow_avail) begin
                state_d     = ST_HDR;
                out_valid_d = 1'b1;
                out_data_d  = make_header(follow_snap);
                out_last_d  = 1'b0;
            end else begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_last_d  = 1'b0;
            end
        end
    end

    // Sequence numbering and sticky drop flag; drops do not consume a number
    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q | drop;
        if (in_valid && !drop) begin
            seq_d = seq_q + SEQ_W'(1);
        end
    end

    // Serializer FSM with registered stream outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Sequence counter and overflow registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign count     = fifo_count;

endmodule

// File: tb/tb_mips_result_serializer.sv
// tb/tb_mips_result_serializer.sv - directed self-checking bench for mips_result_serializer (MIPS_SER_CHECKSUM_EN aware)
module tb_mips_result_serializer;

    localparam int DEPTH = 4;
`ifdef MIPS_SER_CHECKSUM_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_fail;
    logic [15:0] in_r0, in_r1, in_r2, in_r3, in_r4, in_r5;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        overflow;
    logic [2:0]  count;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_beats [8];

    always #5 clk = ~clk;

    mips_result_serializer #(
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_fail    (in_fail),
        .in_r0      (in_r0),
        .in_r1      (in_r1),
        .in_r2      (in_r2),
        .in_r3      (in_r3),
        .in_r4      (in_r4),
        .in_r5      (in_r5),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .overflow   (overflow),
        .count      (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_input(input logic fail, input logic [15:0] base);
        in_valid = 1'b1;
        in_fail  = fail;
        in_r0    = base;
        in_r1    = base + 16'd1;
        in_r2    = base + 16'd2;
        in_r3    = base + 16'd3;
        in_r4    = base + 16'd4;
        in_r5    = base + 16'd5;
    endtask

    task automatic push(input logic fail, input logic [15:0] base);
        apply_input(fail, base);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic build_expected(input logic fail, input logic [11:0] seq, input logic [15:0] base);
        logic [15:0] csum;
        exp_beats[0] = {fail, 3'b000, seq};
        csum = exp_beats[0];
        for (int i = 0; i < 6; i++) begin
            exp_beats[i+1] = base + 16'(i);
            csum = csum ^ exp_beats[i+1];
        end
        exp_beats[7] = csum;
    endtask

    task automatic drain_beats(input int first, input int last_excl, input bit strict, input string name);
        int budget;
        out_ready = 1'b1;
        for (int b = first; b < last_excl; b++) begin
            budget = (b == first && !strict) ? 20 : 0;
            while (out_valid !== 1'b1 && budget > 0) begin
                tick();
                budget--;
            end
            checks++;
            if (out_valid !== 1'b1) $display("FAIL %s beat%0d valid: got %b want 1", name, b, out_valid);
            else passes++;
            checks++;
            if (out_data !== exp_beats[b]) $display("FAIL %s beat%0d data: got %h want %h", name, b, out_data, exp_beats[b]);
            else passes++;
            checks++;
            if (out_last !== (b == NB-1)) $display("FAIL %s beat%0d last: got %b want %b", name, b, out_last, (b == NB-1));
            else passes++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else passes++;
        checks++; if (out_data !== 16'h0000) $display("FAIL reset out_data: got %h want 0000", out_data); else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset out_last: got %b want 0", out_last); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset overflow: got %b want 0", overflow); else passes++;
        checks++; if (count !== 3'd0) $display("FAIL reset count: got %0d want 0", count); else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        build_expected(1'b0, 12'd0, 16'h0001);
        apply_input(1'b0, 16'h0001);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL single early_valid: got %b want 0", out_valid); else passes++;
        checks++; if (count !== 3'd1) $display("FAIL single count: got %0d want 1", count); else passes++;
        tick();
        drain_beats(0, NB, 1'b1, "single");
        checks++; if (out_valid !== 1'b0) $display("FAIL single idle_after: got %b want 0", out_valid); else passes++;
        checks++; if (count !== 3'd0) $display("FAIL single count_after: got %0d want 0", count); else passes++;
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        build_expected(1'b0, 12'd1, 16'h0001);
        push(1'b0, 16'h0001);
        drain_beats(0, 3, 1'b0, "stall_pre");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h0003 || out_last !== 1'b0)
                $display("FAIL stall hold%0d: got valid=%b data=%h last=%b want 1/0003/0", i, out_valid, out_data, out_last);
            else passes++;
            tick();
        end
        drain_beats(3, NB, 1'b1, "stall_post");
        checks++; if (count !== 3'd0) $display("FAIL stall count_after: got %0d want 0", count); else passes++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        push(1'b0, 16'h1000);
        push(1'b1, 16'h2000);
        build_expected(1'b0, 12'd2, 16'h1000);
        drain_beats(0, NB, 1'b0, "b2b_a");
        build_expected(1'b1, 12'd3, 16'h2000);
        drain_beats(0, NB-1, 1'b1, "b2b_b");
        apply_input(1'b0, 16'h3000);
        drain_beats(NB-1, NB, 1'b1, "b2b_b_last");
        in_valid = 1'b0;
        build_expected(1'b0, 12'd4, 16'h3000);
        drain_beats(0, NB, 1'b1, "b2b_c");
        checks++; if (count !== 3'd0) $display("FAIL b2b count_after: got %0d want 0", count); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL b2b overflow: got %b want 0", overflow); else passes++;
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(1'b0, 16'h4000 + 16'(k) * 16'h0100);
        checks++; if (count !== 3'd4) $display("FAIL fullpop count_full: got %0d want 4", count); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL fullpop overflow_pre: got %b want 0", overflow); else passes++;
        build_expected(1'b0, 12'd5, 16'h4000);
        drain_beats(0, NB-1, 1'b0, "fullpop_first");
        apply_input(1'b1, 16'h4400);
        drain_beats(NB-1, NB, 1'b1, "fullpop_first_last");
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b0) $display("FAIL fullpop overflow_post: got %b want 0", overflow); else passes++;
        checks++; if (count !== 3'd4) $display("FAIL fullpop count_post: got %0d want 4", count); else passes++;
        for (int k = 1; k < 5; k++) begin
            build_expected(k == 4, 12'(5 + k), 16'h4000 + 16'(k) * 16'h0100);
            drain_beats(0, NB, 1'b1, "fullpop_rest");
        end
        checks++; if (count !== 3'd0) $display("FAIL fullpop count_end: got %0d want 0", count); else passes++;
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) push(1'b0, 16'h5000 + 16'(k) * 16'h0010);
        checks++; if (count !== 3'd4) $display("FAIL overflow count: got %0d want 4", count); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL overflow flag: got %b want 1", overflow); else passes++;
        for (int k = 0; k < 4; k++) begin
            build_expected(1'b0, 12'(k), 16'h5000 + 16'(k) * 16'h0010);
            drain_beats(0, NB, k != 0, "overflow_drain");
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL overflow extra_snapshot: got valid=%b want 0", out_valid); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL overflow sticky: got %b want 1", overflow); else passes++;
        build_expected(1'b0, 12'd4, 16'h6000);
        push(1'b0, 16'h6000);
        drain_beats(0, NB, 1'b0, "overflow_seq_after_drop");
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        build_expected(1'b0, 12'd5, 16'h7000);
        push(1'b0, 16'h7000);
        drain_beats(0, 3, 1'b0, "resetmid_pre");
        rst_n = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL resetmid valid: got %b want 0", out_valid); else passes++;
        checks++; if (count !== 3'd0) $display("FAIL resetmid count: got %0d want 0", count); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL resetmid overflow: got %b want 0", overflow); else passes++;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen != 0) $display("FAIL resetmid partial_beats: got %0d valid cycles want 0", seen); else passes++;
        build_expected(1'b0, 12'd0, 16'h7100);
        push(1'b0, 16'h7100);
        drain_beats(0, NB, 1'b0, "resetmid_after");
    endtask

    task automatic test_wrap();
        int budget;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            push(1'b0, 16'(i));
            repeat (7) tick();
        end
        budget = 20;
        while (out_valid !== 1'b0 && budget > 0) begin
            tick();
            budget--;
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL wrap drain_timeout: got valid=%b want 0", out_valid); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL wrap overflow: got %b want 0", overflow); else passes++;
        build_expected(1'b1, 12'd0, 16'hABC0);
        push(1'b1, 16'hABC0);
        drain_beats(0, NB, 1'b0, "wrap_final");
    endtask

`ifdef MIPS_SER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        out_ready = 1'b1;
        build_expected(1'b0, 12'd0, 16'h0001);
        push(1'b0, 16'h0001);
        drain_beats(0, 7, 1'b0, "csum_body");
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0007 || out_last !== 1'b1)
            $display("FAIL csum beat: got valid=%b data=%h last=%b want 1/0007/1", out_valid, out_data, out_last);
        else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL csum idle_after: got %b want 0", out_valid); else passes++;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fail   = 1'b0;
        in_r0     = '0;
        in_r1     = '0;
        in_r2     = '0;
        in_r3     = '0;
        in_r4     = '0;
        in_r5     = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_full_pop();
        test_overflow();
        test_reset_mid();
        test_wrap();
`ifdef MIPS_SER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mips_result_serializer.md
MIPS_RESULT_SERIALIZER -- requirements
Module: mips_result_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning snapshot FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-004 The block SHALL have port in_valid, input, 1, high for one cycle when the upstream ALU stage presents a result snapshot.
REQ-005 The block SHALL have port in_fail, input, 1, instruction-fail flag of the presented snapshot.
REQ-006 The block SHALL have ports in_r0..in_r5, input, 16 each, the six architectural register values of the snapshot.
REQ-007 The block SHALL have port out_valid, output, 1, a serial beat is presented.
REQ-008 The block SHALL have port out_ready, input, 1, the consumer accepts the beat.
REQ-009 The block SHALL have port out_data, output, 16, the serial beat payload.
REQ-010 The block SHALL have port out_last, output, 1, high on the final beat of a snapshot.
REQ-011 The block SHALL have port overflow, output, 1, sticky flag set when a snapshot is dropped.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1), number of snapshots held, including the one being serialized.

Function
REQ-013 On in_valid, the block SHALL capture {in_fail, in_r0..in_r5} and a 12-bit sequence number into the FIFO, with no input back-pressure.
REQ-014 The sequence number SHALL start at 0, increment once per accepted snapshot, and wrap from 4095 to 0; dropped snapshots SHALL NOT consume a number.
REQ-015 Each snapshot SHALL be sent as a header beat, then data beats in_r0..in_r5 in order; out_last SHALL be high only on the final beat.
REQ-016 Header beat format SHALL be bit15 = fail, bits14:12 = 3'b000, bits11:0 = sequence number.
REQ-017 The FSM SHALL have states IDLE, HDR, DATA (3-bit beat index 0..5) and CSUM (present only under REQ-028).
REQ-018 FSM transitions SHALL be: IDLE->HDR when the FIFO is non-empty; HDR->DATA on handshake; DATA index advances on handshake; DATA index 5 handshake -> CSUM if enabled, else HDR if another snapshot is queued, else IDLE; CSUM handshake -> HDR or IDLE by the same rule.
REQ-019 A beat SHALL transfer only in a cycle where out_valid and out_ready are both high; out_data and out_last SHALL hold stable while out_valid is high and out_ready is low.
REQ-020 out_valid SHALL be high in HDR, DATA and CSUM, and low in IDLE.
REQ-021 Latency: a snapshot arriving at edge N into an empty, idle block SHALL present its header with out_valid high after edge N+1.
REQ-022 Throughput: back-to-back snapshots with out_ready held high SHALL have no idle cycle between the last beat of one snapshot and the header of the next.
REQ-023 The FIFO entry SHALL be popped on the handshake of the snapshot's final beat.
REQ-024 A push while full SHALL be accepted if the final-beat pop occurs in the same cycle; otherwise the snapshot SHALL be dropped, the FIFO left unchanged, and overflow set.
REQ-025 overflow SHALL stay high until reset.
REQ-026 Reset asserted mid-snapshot SHALL abandon the snapshot, with no partial beats after reset.

Reset
REQ-027 While rst_n is low at a rising edge, the block SHALL clear: out_valid=0, out_data=0, out_last=0, overflow=0, count=0, FSM=IDLE, sequence=0, FIFO pointers=0; FIFO storage need not be cleared.

Configuration
REQ-028 With macro MIPS_SER_CHECKSUM_EN defined, each snapshot SHALL append a CSUM beat equal to the XOR of the header and the six data words, and out_last SHALL move to that beat (8 beats total); without the macro, the CSUM state and logic SHALL be absent and snapshots SHALL be 7 beats.

Structure
REQ-029 Shared package mips_pkg SHALL hold: the FSM state enum, the header field positions, the constants NUM_REGS=6 and SEQ_W=12, and the snapshot struct typedef.
REQ-030 The FIFO SHALL be a separate sub-module, mips_snapshot_fifo (parameter DEPTH, push/pop/full/empty/count); the serializer FSM SHALL live in the top module.

Verification
REQ-031 Single snapshot: fail=0, r0..r5=1,2,3,4,5,6, out_ready=1 -> beats 0x0000,1,2,3,4,5,6, out_last on 0x0006, header visible one cycle after in_valid.
REQ-032 Stall: out_ready low for 3 cycles during the r2 beat -> out_data=0x0003 held steady, then the sequence resumes intact.
REQ-033 Fail plus wrap: 4097 snapshots, last with fail=1 -> final header = 0x8000 (sequence wrapped to 0, fail bit set).
REQ-034 Overflow: DEPTH=4, out_ready=0, 6 snapshots -> count=4, overflow=1, then release out_ready -> only the first 4 are serialized, with sequences 0..3.
REQ-035 Full plus simultaneous pop: FIFO full and in_valid in the final-beat handshake cycle -> snapshot accepted, overflow stays 0, count unchanged.
REQ-036 Checksum (macro defined): r0..r5=0x0001..0x0006, header 0x0000 -> CSUM beat = 0x0007 with out_last set.
